// File: rtl/sprite_pkg.sv
// Shared types for the sprite palette lookup: flash FSM states, the packed
// {R,G,B} colour type and the channel override helper used by the flash.
package sprite_pkg;

    // Channel width of the packed colour type; matches the default CW of the top.
    localparam int CHAN_W = 4;

    typedef enum logic [1:0] {
        FLASH_IDLE = 2'd0,
        FLASH_ON   = 2'd1,
        FLASH_OFF  = 2'd2
    } flash_state_t;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb_t;

    // Force a channel to full intensity while a flash override is active.
    function automatic logic [CHAN_W-1:0] flash_chan(input logic [CHAN_W-1:0] c,
                                                     input logic force_on);
        logic [CHAN_W-1:0] res;
        if (force_on) begin
            res = {CHAN_W{1'b1}};
        end else begin
            res = c;
        end
        return res;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// Palette storage: one write port, one synchronous read port, write-first.
// Contents are intentionally not reset; the colour tables survive a reset.
module palette_ram #(
    parameter int AW = 6,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Write port and registered read; a same-address write is forwarded to the read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/sprite_palette_lut.sv
// Sprite palette lookup with transparency detection and an optional hit-flash.
// Two-stage pipeline: stage 1 is the synchronous RAM read, stage 2 registers
// the colour (with flash override) and the transparency flag.
// Optional feature macro: SPRITE_PALETTE_FLASH_EN enables the flash FSM; without
// it flash_busy stays 0 and flash_req/frame_tick are ignored.
module sprite_palette_lut
    import sprite_pkg::*;
#(
    parameter int              NUM_PAL      = 4,
    parameter int              IDX_W        = 4,
    parameter int              CW           = 4,
    parameter logic [3*CW-1:0] KEY_RGB      = 12'hF0F,
    parameter int              FLASH_FRAMES = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       rd_en,
    input  logic [$clog2(NUM_PAL)-1:0] pal_sel,
    input  logic [IDX_W-1:0]           index,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [3*CW-1:0]            wr_rgb,
    input  logic                       frame_tick,
    input  logic                       flash_req,
    output logic [CW-1:0]              red,
    output logic [CW-1:0]              green,
    output logic [CW-1:0]              blue,
    output logic                       rgb_valid,
    output logic                       transparent,
    output logic                       flash_busy
);

    localparam int PAL_W = $clog2(NUM_PAL);
    localparam int AW    = PAL_W + IDX_W;
    localparam int DW    = 3 * CW;

    logic [DW-1:0] ram_rdata;
    rgb_t          ram_q;
    logic          rd_v1;
    logic          is_key;
    logic          flash_on;

    palette_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (Clk),
        .we    (wr_en),
        .waddr ({wr_pal, wr_idx}),
        .wdata (wr_rgb),
        .re    (rd_en),
        .raddr ({pal_sel, index}),
        .rdata (ram_rdata)
    );

    assign ram_q  = ram_rdata;
    assign is_key = (ram_rdata == KEY_RGB);

    // Stage-1 valid bit tracks which RAM reads are real lookups.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_v1 <= 1'b0;
        end else begin
            rd_v1 <= rd_en;
        end
    end

`ifdef SPRITE_PALETTE_FLASH_EN
    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

    flash_state_t     state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    // Flash state and frame counter registers; reset aborts any running flash.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= FLASH_IDLE;
            cnt        <= {CNT_W{1'b0}};
            flash_busy <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            flash_busy <= (state_next != FLASH_IDLE);
        end
    end

    // Next-state: start on request, then toggle ON/OFF per frame until the count runs out.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            FLASH_IDLE: begin
                // A tick in the starting cycle is not counted.
                if (flash_req) begin
                    state_next = FLASH_ON;
                    cnt_next   = CNT_W'(FLASH_FRAMES);
                end else begin
                    state_next = FLASH_IDLE;
                end
            end
            FLASH_ON, FLASH_OFF: begin
                if (frame_tick) begin
                    cnt_next = cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_next = FLASH_IDLE;
                    end else if (state == FLASH_ON) begin
                        state_next = FLASH_OFF;
                    end else begin
                        state_next = FLASH_ON;
                    end
                end else begin
                    state_next = state;
                end
            end
            default: begin
                state_next = FLASH_IDLE;
                cnt_next   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign flash_on = (state == FLASH_ON);
`else
    logic unused_flash_inputs;
    assign unused_flash_inputs = flash_req ^ frame_tick;
    assign flash_on            = 1'b0;
    assign flash_busy          = 1'b0;
`endif

    // Stage-2 output registers; hold their value on cycles without a lookup.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            red         <= {CW{1'b0}};
            green       <= {CW{1'b0}};
            blue        <= {CW{1'b0}};
            transparent <= 1'b0;
            rgb_valid   <= 1'b0;
        end else begin
            rgb_valid <= rd_v1;
            if (rd_v1) begin
                // Transparency is judged on the stored colour, so keyed pixels never flash.
                red         <= flash_chan(ram_q.r, flash_on && !is_key);
                green       <= flash_chan(ram_q.g, flash_on && !is_key);
                blue        <= flash_chan(ram_q.b, flash_on && !is_key);
                transparent <= is_key;
            end
        end
    end

endmodule
